// File: rtl/cop0_irq_ctrl.sv
// Interrupt source block feeding CP0 Cause: synchronizes external irq lines,
// latches level/edge pending bits and hosts the Count/Compare timer.
module cop0_irq_ctrl #(
    parameter int                     NUM_EXT_IRQ = 6,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [NUM_EXT_IRQ-1:0] EDGE_MASK   = '0,
    parameter int                     TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_EXT_IRQ-1:0] irq_in,
    input  logic [NUM_EXT_IRQ-1:0] irq_ack,
    input  logic                   count_en,
    input  logic                   wr_en,
    input  logic [4:0]             wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [4:0]             rd_addr,
    output logic [31:0]            rd_data,
    output logic [31:0]            ext_cause,
    output logic                   timer_irq
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;

    logic [SYNC_STAGES-1:0][NUM_EXT_IRQ-1:0] sync_reg;
    logic [NUM_EXT_IRQ-1:0] sync_s;
    logic [NUM_EXT_IRQ-1:0] s_d_reg;
    logic [NUM_EXT_IRQ-1:0] pend_reg;
    logic [NUM_EXT_IRQ-1:0] pend_next;

    logic [TIMER_WIDTH-1:0] count_reg;
    logic [TIMER_WIDTH-1:0] count_next;
    logic [TIMER_WIDTH-1:0] compare_reg;
    logic                   timer_pend_reg;
    logic                   timer_pend_next;
    logic [31:0]            rd_data_next;

    logic wr_count;
    logic wr_compare;

    assign sync_s     = sync_reg[SYNC_STAGES-1];
    assign wr_count   = wr_en && (wr_addr == ADDR_COUNT);
    assign wr_compare = wr_en && (wr_addr == ADDR_COMPARE);

    // Stage 0 samples the asynchronous lines; the last stage is the safe copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            s_d_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
            s_d_reg  <= sync_s;
        end
    end

    // Per-line pending logic: an edge arriving with an ack keeps the bit set.
    generate
        for (genvar gi = 0; gi < NUM_EXT_IRQ; gi++) begin : g_line
            if (EDGE_MASK[gi]) begin : g_edge
                assign pend_next[gi] = (sync_s[gi] & ~s_d_reg[gi]) |
                                       (pend_reg[gi] & ~irq_ack[gi]);
            end else begin : g_level
                assign pend_next[gi] = sync_s[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (wr_count) begin
            count_next = wr_data[TIMER_WIDTH-1:0];
        end else if (count_en) begin
            count_next = count_reg + TIMER_WIDTH'(1);
        end
    end

    // Match uses registered values; a Compare write in the same cycle wins.
    always_comb begin
        timer_pend_next = timer_pend_reg;
        if (wr_compare) begin
            timer_pend_next = 1'b0;
        end else if (count_reg == compare_reg) begin
            timer_pend_next = 1'b1;
        end
    end

    always_comb begin
        rd_data_next = '0;
        case (rd_addr)
            ADDR_COUNT:   rd_data_next = 32'(count_reg);
            ADDR_COMPARE: rd_data_next = 32'(compare_reg);
            default:      rd_data_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            compare_reg    <= '1;
            timer_pend_reg <= 1'b0;
            rd_data        <= '0;
        end else begin
            count_reg      <= count_next;
            timer_pend_reg <= timer_pend_next;
            rd_data        <= rd_data_next;
            if (wr_compare) begin
                compare_reg <= wr_data[TIMER_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ext_cause = '0;
        for (int k = 0; k < NUM_EXT_IRQ; k++) begin
            ext_cause[15-k] = pend_reg[NUM_EXT_IRQ-1-k];
        end
        ext_cause[15] = ext_cause[15] | timer_pend_reg;
    end

    assign timer_irq = timer_pend_reg;

endmodule
